blink_count_tx: RTL and testbench

//  Transmits a numeric value to a human observer as a burst of LED blinks:

---
 rtl/blink_count_tx_pkg.sv | 29 ++
 rtl/blink_count_tx_timer.sv | 26 ++
 rtl/blink_count_tx.sv | 112 +++++++++++
 tb/tb_blink_count_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/blink_count_tx_pkg.sv
// Shared types and helpers for the LED blink-count transmitter.
// Holds the FSM state encoding, the board clock rate and timer sizing helpers.
package blink_count_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned CLK_HZ = 27_000_000;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A one-cycle phase still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/blink_count_tx_timer.sv
// Phase timer: counts up from zero, clears on request, flags a runtime limit.
// The terminal flag is decoded from the registered count.
import blink_count_tx_pkg::*;

module blink_count_tx_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic [TW-1:0] limit,
    output logic          term
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign term = (count == limit);

endmodule

// File: rtl/blink_count_tx.sv
// Blink-count transmitter: shows a value N as N LED pulses, a gap, then done.
// One timer is shared by all phases and restarts on every state change.
import blink_count_tx_pkg::*;

module blink_count_tx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ON_CYCLES  = 5_400_000,
    parameter int unsigned OFF_CYCLES = 5_400_000,
    parameter int unsigned GAP_CYCLES = 27_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             led
);

    localparam int unsigned TW =
        cnt_width(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES));

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic [TW-1:0]    limit;
    logic             term;
    logic             clear;

    always_comb begin
        limit = '0;
        case (state)
            ST_ON:   limit = ON_LAST;
            ST_OFF:  limit = OFF_LAST;
            ST_GAP:  limit = GAP_LAST;
            default: limit = '0;
        endcase
    end

    // Idle keeps the timer at zero so every phase starts from a clean count.
    assign clear = rst || (state == ST_IDLE) || term;

    blink_count_tx_timer #(
        .TW(TW)
    ) u_timer (
        .clk   (clk),
        .clear (clear),
        .limit (limit),
        .term  (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            led       <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= value;
                        busy      <= 1'b1;
                        if (value != '0) begin
                            state <= ST_ON;
                            led   <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_ON: begin
                    if (term) begin
                        led <= 1'b1;
                        if (remaining != '0) begin
                            remaining <= remaining - WIDTH'(1);
                        end
                        if (remaining <= WIDTH'(1)) begin
                            state <= ST_GAP;
                        end else begin
                            state <= ST_OFF;
                        end
                    end
                end
                ST_OFF: begin
                    if (term) begin
                        state <= ST_ON;
                        led   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (term) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    led   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_count_tx.sv
// Bench for blink_count_tx with short phases (ON=3, OFF=2, GAP=5, WIDTH=4).
// A timeline model predicts led/busy/done every cycle from burst offsets.
module tb_blink_count_tx;

    localparam int W   = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int GAP = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] value;
    logic         busy;
    logic         done;
    logic         led;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    blink_count_tx #(
        .WIDTH      (W),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .led   (led)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int blen(input int n);
        return (n == 0) ? GAP : n * ON + (n - 1) * OFF + GAP;
    endfunction

    // Expected led at offset t (1-based) within a burst of n pulses.
    function automatic logic led_at(input int n, input int t);
        int p;
        p = t - 1;
        if (n == 0) return 1'b1;
        if (p >= n * ON + (n - 1) * OFF) return 1'b1;
        return ((p % (ON + OFF)) < ON) ? 1'b0 : 1'b1;
    endfunction

    bit m_act  = 0;
    bit m_done = 0;
    int m_t    = 0;
    int m_n    = 0;
    int m_len  = 0;
    int n_done_exp  = 0;
    int n_done_seen = 0;

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_act = 0;
        end else if (m_act) begin
            m_t++;
            if (m_t > m_len) begin
                m_act = 0;
                m_done = 1;
                n_done_exp++;
            end
        end else if (start) begin
            m_act = 1;
            m_n   = int'(value);
            m_t   = 1;
            m_len = blen(m_n);
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_act});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("led", {31'd0, led},
            {31'd0, (m_act ? led_at(m_n, m_t) : 1'b1)});
        if (done === 1'b1) n_done_seen++;
    end

    task automatic idle_wait(input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || m_act) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("timeout", 32'd0, 32'd1);
    endtask

    // Launch one burst and measure busy length and number of lit pulses.
    task automatic burst(input int v);
        int  cnt;
        int  pulses;
        int  k;
        logic prev;
        start = 1'b1;
        value = W'(v);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        pulses = 0;
        prev = 1'b1;
        k = 0;
        while (busy === 1'b1 && k < 300) begin
            cnt++;
            if (led === 1'b0 && prev === 1'b1) pulses++;
            prev = led;
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("timeout", 32'd0, 32'd1);
        chk("blen", cnt, blen(v));
        chk("pulses", pulses, v);
        @(negedge clk);
    endtask

    initial begin
        int v;
        int cut;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst_led", {31'd0, led}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_led", {31'd0, led}, 32'd1);

        burst(2);
        burst(0);
        burst(15);

        start = 1'b1;
        value = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        value = 4'd7;
        @(negedge clk);
        start = 1'b0;
        idle_wait(100);
        @(negedge clk);

        start = 1'b1;
        value = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_led", {31'd0, led}, 32'd1);
        burst(1);

        start = 1'b1;
        value = 4'd1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        idle_wait(100);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 15);
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 30) : -1;
            start = 1'b1;
            value = W'(v);
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 300) begin
                if ($urandom_range(0, 4) == 0) begin
                    start = 1'b1;
                    value = W'($urandom);
                end else begin
                    start = 1'b0;
                end
                rst = (n == cut);
                @(negedge clk);
                n++;
            end
            if (n >= 300) chk("timeout", 32'd0, 32'd1);
            start = 1'b0;
            rst   = 1'b0;
            idle_wait(100);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        chk("ndone", n_done_seen, n_done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
